// File: rtl/hll_rho_if.sv
// hll_rho_if
//   Bundles the beat-level signals of the pipelined rho unit.
//   Handshake: a beat moves on an edge where valid and ready are both high;
//   a producer holds its valid beat, unchanged, until ready is seen.
//   Signals:
//     zero_mode, in_data, in_tag, in_valid -> unit   (input beat)
//     in_ready                             <- unit
//     out_rho, out_tag, out_valid          <- unit   (output beat)
//     out_ready                            -> unit
//     zero_cnt                             <- unit   (all-zero beats delivered)
//   master: the side feeding and draining the unit; slave: the unit itself.
interface hll_rho_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 8,
    parameter int RHO_W  = $clog2(DATA_W + 2)
) ();
    logic              zero_mode;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              in_valid;
    logic              in_ready;
    logic [RHO_W-1:0]  out_rho;
    logic [TAG_W-1:0]  out_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       zero_cnt;

    modport master (
        output zero_mode, in_data, in_tag, in_valid, out_ready,
        input  in_ready, out_rho, out_tag, out_valid, zero_cnt
    );

    modport slave (
        input  zero_mode, in_data, in_tag, in_valid, out_ready,
        output in_ready, out_rho, out_tag, out_valid, zero_cnt
    );
endinterface

// File: rtl/hll_rho_pipe.sv
// hll_rho_pipe
//   Pipelined leading-one detector for the HLL kernel:
//   rho = (leading zeros of in_data) + 1, capped at SAT_RHO.
//   The datum is scanned GROUP_W bits per stage, MSB group first, so the
//   pipe has NG = DATA_W/GROUP_W scan stages, one offset stage and one
//   output stage (latency NG+2). A tag and the zero_mode bit ride along
//   with every beat.
//   Ports:
//     clk  - clock, all logic on posedge
//     rst  - synchronous active-high reset
//     bus  - hll_rho_if.slave: input beat (zero_mode/in_data/in_tag/
//            in_valid/in_ready), output beat (out_rho/out_tag/out_valid/
//            out_ready) and the zero_cnt statistic.
//   Constraints: DATA_W a multiple of GROUP_W, DATA_W >= 2,
//   1 <= SAT_RHO <= DATA_W+1.
module hll_rho_pipe #(
    parameter int  DATA_W  = 16,
    parameter int  GROUP_W = 4,
    parameter int  TAG_W   = 8,
    parameter int  SAT_RHO = DATA_W + 1,
    localparam int RHO_W   = $clog2(DATA_W + 2)
) (
    input  logic      clk,
    input  logic      rst,
    hll_rho_if.slave  bus
);
    localparam int NG     = DATA_W / GROUP_W;
    localparam int NS     = NG + 2;
    localparam int GIDX_W = (NG > 1) ? $clog2(NG) : 1;
    localparam int GLZ_W  = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;

    localparam logic [RHO_W-1:0] ZERO_RHO = RHO_W'(DATA_W + 1);
    localparam logic [RHO_W-1:0] CAP_RHO  = RHO_W'(SAT_RHO);

    // One pipeline slot. found/gidx/glz record the first nonzero group seen
    // so far; rho is filled by the offset stage and finalised by the last.
    typedef struct packed {
        logic              valid;
        logic              zmode;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              found;
        logic [GIDX_W-1:0] gidx;
        logic [GLZ_W-1:0]  glz;
        logic [RHO_W-1:0]  rho;
    } stage_t;

    stage_t      stg_q [NS];
    stage_t      stg_d [NS];
    logic [31:0] zero_cnt_q;
    logic [31:0] zero_cnt_d;

    logic        en;
    logic        in_ready_w;
    logic        accept;
    logic        deliver;
    int          off;

    // Leading zeros inside one group; only meaningful when the group is nonzero.
    function automatic logic [GLZ_W-1:0] group_lz(input logic [GROUP_W-1:0] g);
        logic [GLZ_W-1:0] lz;
        logic             hit;
        lz  = '0;
        hit = 1'b0;
        for (int i = GROUP_W - 1; i >= 0; i--) begin
            if (!hit && g[i]) begin
                hit = 1'b1;
                lz  = GLZ_W'(GROUP_W - 1 - i);
            end
        end
        return lz;
    endfunction

    // Global stall: the whole pipe freezes while the output beat waits.
    assign en         = !(stg_q[NS-1].valid && !bus.out_ready);
    assign in_ready_w = en && !rst;
    assign accept     = bus.in_valid && in_ready_w;
    assign deliver    = stg_q[NS-1].valid && bus.out_ready;

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            stg_d[s] = stg_q[s];
        end
        off = 0;

        if (en) begin
            // Stage 1: capture the beat and scan the MSB group.
            stg_d[0].valid = accept;
            stg_d[0].zmode = bus.zero_mode;
            stg_d[0].tag   = bus.in_tag;
            stg_d[0].data  = bus.in_data;
            stg_d[0].found = |bus.in_data[DATA_W-1 -: GROUP_W];
            stg_d[0].gidx  = '0;
            stg_d[0].glz   = group_lz(bus.in_data[DATA_W-1 -: GROUP_W]);
            stg_d[0].rho   = '0;

            // Stages 2..NG: scan the next group only if nothing was found yet.
            for (int k = 1; k < NG; k++) begin
                stg_d[k] = stg_q[k-1];
                if (!stg_q[k-1].found && (|stg_q[k-1].data[DATA_W-1-k*GROUP_W -: GROUP_W])) begin
                    stg_d[k].found = 1'b1;
                    stg_d[k].gidx  = GIDX_W'(k);
                    stg_d[k].glz   = group_lz(stg_q[k-1].data[DATA_W-1-k*GROUP_W -: GROUP_W]);
                end
            end

            // Offset stage: rho = group_index*GROUP_W + lz_in_group + 1.
            // Max value is DATA_W, which RHO_W holds without wrapping.
            stg_d[NG] = stg_q[NG-1];
            off = int'(stg_q[NG-1].gidx) * GROUP_W + int'(stg_q[NG-1].glz) + 1;
            stg_d[NG].rho = stg_q[NG-1].found ? RHO_W'(off) : '0;

            // Output stage: all-zero substitution, then the saturation cap.
            stg_d[NG+1] = stg_q[NG];
            if (!stg_q[NG].found) begin
                stg_d[NG+1].rho = stg_q[NG].zmode ? ZERO_RHO : '0;
            end
            if (stg_d[NG+1].rho > CAP_RHO) begin
                stg_d[NG+1].rho = CAP_RHO;
            end
        end

        zero_cnt_d = zero_cnt_q;
        if (deliver && !stg_q[NS-1].found) begin
            zero_cnt_d = zero_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                stg_q[s] <= '0;
            end
            zero_cnt_q <= '0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                stg_q[s] <= stg_d[s];
            end
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = stg_q[NS-1].valid;
    assign bus.out_rho   = stg_q[NS-1].rho;
    assign bus.out_tag   = stg_q[NS-1].tag;
    assign bus.zero_cnt  = zero_cnt_q;
endmodule

// File: tb/tb_hll_rho_pipe.sv
// tb_hll_rho_pipe
//   Bench for hll_rho_pipe (DATA_W=16, GROUP_W=4, TAG_W=8): one default
//   instance driven by directed and random beats against a scoreboard, and
//   one SAT_RHO=8 instance for the cap cases.
module tb_hll_rho_pipe;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 8;
    localparam int RHO_W  = 5;
    localparam int LAT    = 6;
    localparam int W      = 1 + RHO_W + TAG_W;

    logic clk;
    logic rst;

    hll_rho_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) b1 ();
    hll_rho_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) b2 ();

    hll_rho_pipe #(.DATA_W(DATA_W), .GROUP_W(4), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    hll_rho_pipe #(.DATA_W(DATA_W), .GROUP_W(4), .TAG_W(TAG_W), .SAT_RHO(8)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0]     exp_q [$];
    logic [31:0]      exp_zero;
    int               n_tests;
    int               n_fail;
    int               acc_cnt;
    logic             prev_stall;
    logic [RHO_W-1:0] prev_rho;
    logic [TAG_W-1:0] prev_tag;

    // reference: position of the highest set bit, plain arithmetic
    function automatic logic [RHO_W-1:0] ref_rho(input logic [DATA_W-1:0] d, input logic zm, input int sat);
        int r;
        r = zm ? DATA_W + 1 : 0;
        for (int k = 0; k < DATA_W; k++) begin
            if (d[k]) r = DATA_W - k;
        end
        if (r > sat) r = sat;
        return RHO_W'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on dut: drive at negedge, evaluate the handshakes of the
    // coming posedge at negedge+1.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                        input logic zm, input logic ordy, input logic r);
        logic [W-1:0] e;
        @(negedge clk);
        rst          = r;
        b1.in_valid  = v;
        b1.in_data   = d;
        b1.in_tag    = t;
        b1.zero_mode = zm;
        b1.out_ready = ordy;
        #1;
        check("zero_cnt", b1.zero_cnt, exp_zero);
        if (prev_stall) begin
            check("hold_valid", {31'd0, b1.out_valid}, 32'd1);
            check("hold_rho", {27'd0, b1.out_rho}, {27'd0, prev_rho});
            check("hold_tag", {24'd0, b1.out_tag}, {24'd0, prev_tag});
        end
        prev_stall = b1.out_valid && !b1.out_ready && !r;
        prev_rho   = b1.out_rho;
        prev_tag   = b1.out_tag;
        if (r) begin
            check("in_ready_rst", {31'd0, b1.in_ready}, 32'd0);
            exp_q.delete();
            exp_zero   = 32'd0;
            prev_stall = 1'b0;
        end else begin
            if (b1.out_valid && b1.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {31'd0, b1.out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_rho", {27'd0, b1.out_rho}, {27'd0, e[W-2 -: RHO_W]});
                    check("out_tag", {24'd0, b1.out_tag}, {24'd0, e[TAG_W-1:0]});
                    if (e[W-1]) exp_zero = exp_zero + 32'd1;
                end
            end
            if (b1.in_valid && b1.in_ready) begin
                exp_q.push_back({(d == '0), ref_rho(d, zm, DATA_W + 1), t});
                acc_cnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    // Single beat into an empty pipe: checks the spec value and the latency.
    task automatic send_one(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t, input logic zm,
                            input logic [RHO_W-1:0] exp_rho, input string nm);
        int lat;
        lat = 0;
        step(1'b1, d, t, zm, 1'b1, 1'b0);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            if (b1.out_valid) begin
                lat = i;
                check({nm, "_rho"}, {27'd0, b1.out_rho}, {27'd0, exp_rho});
                check({nm, "_tag"}, {24'd0, b1.out_tag}, {24'd0, t});
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic sat_one(input logic [DATA_W-1:0] d, input logic [RHO_W-1:0] exp_rho, input string nm);
        int lat;
        lat = 0;
        @(negedge clk);
        b2.in_data   = d;
        b2.in_tag    = 8'h5a;
        b2.zero_mode = 1'b0;
        b2.out_ready = 1'b1;
        b2.in_valid  = 1'b1;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            b2.in_valid = 1'b0;
            #1;
            if (b2.out_valid) begin
                lat = i;
                check({nm, "_rho"}, {27'd0, b2.out_rho}, {27'd0, exp_rho});
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    initial begin
        int drain;
        int started;
        int guard;
        logic [DATA_W-1:0] d;
        logic [1:0] kind;

        rst = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_tag = '0; b1.zero_mode = 1'b0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.in_tag = '0; b2.zero_mode = 1'b0; b2.out_ready = 1'b1;
        exp_zero = '0; n_tests = 0; n_fail = 0; acc_cnt = 0;
        prev_stall = 1'b0; prev_rho = '0; prev_tag = '0;

        // reset state
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("rst_out_valid", {31'd0, b1.out_valid}, 32'd0);
        check("rst_out_rho", {27'd0, b1.out_rho}, 32'd0);
        check("rst_out_tag", {24'd0, b1.out_tag}, 32'd0);
        check("rst_in_ready", {31'd0, b1.in_ready}, 32'd1);

        // directed values
        send_one(16'h8000, 8'h11, 1'b0, 5'd1, "msb");
        send_one(16'h0800, 8'h22, 1'b0, 5'd5, "bit11");
        send_one(16'h0001, 8'h33, 1'b0, 5'd16, "bit0");
        send_one(16'h0000, 8'h44, 1'b0, 5'd0, "zero_m0");
        idle(1);
        check("zero_cnt_1", b1.zero_cnt, 32'd1);
        send_one(16'h0000, 8'h55, 1'b1, 5'd17, "zero_m1");
        idle(1);
        check("zero_cnt_2", b1.zero_cnt, 32'd2);

        // random beats with random backpressure
        acc_cnt = 0;
        guard = 0;
        while (acc_cnt < 100 && guard < 3000) begin
            kind = 2'($urandom_range(0, 3));
            case (kind)
                2'd0:    d = '0;
                2'd1:    d = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
                default: d = DATA_W'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, d, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            guard++;
        end
        check("random_accepted", 32'(acc_cnt), 32'd100);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);
        idle(2);

        // full pipe held for 10 cycles
        for (int i = 0; i < LAT; i++) step(1'b1, DATA_W'($urandom), 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h1234, 8'hee, 1'b0, 1'b0, 1'b0);
            check("stall_in_ready", {31'd0, b1.in_ready}, 32'd0);
        end
        drain = 0;
        started = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            if (b1.out_valid && (started == 0 || started == 1)) begin
                started = 1;
                drain++;
            end else if (started == 1) begin
                started = 2;
            end
        end
        check("stall_drain_count", 32'(drain), 32'(LAT));
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset with three beats in flight
        step(1'b1, 16'h0000, 8'ha1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 8'ha2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h0400, 8'ha3, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("post_rst_out_valid", {31'd0, b1.out_valid}, 32'd0);
        check("post_rst_zero_cnt", b1.zero_cnt, 32'd0);
        send_one(16'h0100, 8'h77, 1'b0, 5'd8, "post_rst");
        idle(3);
        check("post_rst_zero_cnt_end", b1.zero_cnt, 32'd0);

        // saturation build
        sat_one(16'h0010, 5'd8, "sat_cap");
        sat_one(16'h0200, 5'd7, "sat_below");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
